// File: rtl/imem_arbiter_rr_if.sv
// -----------------------------------------------------------------------------
// imem_arbiter_rr_if
// Bundles the requester-side and memory-side signals of imem_arbiter_rr.
//
// Parameters: PORTS (requesters), PORTW (data width), ADDRWIDTH (address width)
//
// Handshake: a requester asserts req_en_x[i] low and holds its address, data,
// write enable and bit mask stable for as long as busy[i] is high. The cycle in
// which busy[i] is low while req_en_x[i] is low is the accepted cycle. For a
// read, q carries the data one cycle later, marked by rvalid[i]. Nothing is
// queued: a request dropped while busy simply disappears.
//
// Signals:
//   req_en_x/req_wr_x       per-port enable / write enable, active low
//   req_addr/req_d          flat per-port address / write data
//   req_bit_wr_x            flat per-port bit write mask, active low
//   mem_en_x/mem_wr_x       memory enable / write enable, active low
//   mem_addr/mem_d          memory address / write data
//   mem_bit_wr_x            memory bit mask, active low
//   mem_q                   memory read data (one cycle after a read)
//   q                       mem_q passed through
//   busy/rvalid             per-port busy / read-data-valid
//   grant_id                granted port index, 0 when idle
//
// Modports: slave = arbiter side, master = requesters plus memory model.
// -----------------------------------------------------------------------------
interface imem_arbiter_rr_if #(
  parameter int PORTS     = 2,
  parameter int PORTW     = 32,
  parameter int ADDRWIDTH = 7
);
  logic [PORTS-1:0]           req_en_x;
  logic [PORTS-1:0]           req_wr_x;
  logic [PORTS*ADDRWIDTH-1:0] req_addr;
  logic [PORTS*PORTW-1:0]     req_d;
  logic [PORTS*PORTW-1:0]     req_bit_wr_x;
  logic                       mem_en_x;
  logic                       mem_wr_x;
  logic [ADDRWIDTH-1:0]       mem_addr;
  logic [PORTW-1:0]           mem_d;
  logic [PORTW-1:0]           mem_bit_wr_x;
  logic [PORTW-1:0]           mem_q;
  logic [PORTW-1:0]           q;
  logic [PORTS-1:0]           busy;
  logic [PORTS-1:0]           rvalid;
  logic [2:0]                 grant_id;

  modport slave (
    input  req_en_x, req_wr_x, req_addr, req_d, req_bit_wr_x, mem_q,
    output mem_en_x, mem_wr_x, mem_addr, mem_d, mem_bit_wr_x, q, busy, rvalid, grant_id
  );

  modport master (
    output req_en_x, req_wr_x, req_addr, req_d, req_bit_wr_x, mem_q,
    input  mem_en_x, mem_wr_x, mem_addr, mem_d, mem_bit_wr_x, q, busy, rvalid, grant_id
  );
endinterface

// File: rtl/imem_arbiter_rr.sv
// -----------------------------------------------------------------------------
// imem_arbiter_rr
// Round-robin arbiter sharing one single-port memory among PORTS requesters.
// The grant is combinational; a rotating pointer gives the port after the last
// winner first priority. Reads raise a one-hot rvalid one cycle later, aligned
// with the memory's read data on q.
//
// Optional feature (macro IMEM_ARB_BURST_LOCK_EN): the owner of the previous
// grant keeps the memory for up to MAX_BURST consecutive cycles while it keeps
// requesting; the pointer is frozen during a locked run. Without the macro the
// arbiter is pure round-robin and MAX_BURST is unused.
//
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous active-high reset
//   bus   imem_arbiter_rr_if.slave (requester and memory signals)
// -----------------------------------------------------------------------------
module imem_arbiter_rr #(
  parameter int PORTS     = 2,
  parameter int PORTW     = 32,
  parameter int ADDRWIDTH = 7,
  parameter int MAX_BURST = 4
) (
  input  logic               clk,
  input  logic               rst,
  imem_arbiter_rr_if.slave   bus
);

  localparam int PW = (PORTS > 1) ? $clog2(PORTS) : 1;

  // Out-of-range configurations elaborate this marker block, which makes a
  // bad parameter set visible in the hierarchy.
  if (PORTS < 2 || PORTS > 8 || MAX_BURST < 1 || MAX_BURST > 15) begin : g_cfg_out_of_range
  end

  logic [PORTS-1:0] w_req;
  logic             w_search_hit;
  logic [PW-1:0]    w_search_idx;
  logic [PW-1:0]    w_idx;
  logic             w_gnt;
  logic             w_lock;
  logic [PW-1:0]    w_g;
  logic [PW-1:0]    r_ptr;
  logic [PORTS-1:0] r_rvalid;

  assign w_req = ~bus.req_en_x;

  // Walk the ports from the farthest to the nearest offset from r_ptr so the
  // last hit written is the nearest requester, with no early exit needed.
  always_comb begin
    w_search_hit = 1'b0;
    w_search_idx = '0;
    w_idx        = '0;
    for (int k = PORTS - 1; k >= 0; k--) begin
      w_idx = PW'((int'(r_ptr) + k) % PORTS);
      if (w_req[w_idx]) begin
        w_search_hit = 1'b1;
        w_search_idx = w_idx;
      end
    end
  end

  // A locked owner is always requesting, so a search hit exists whenever a
  // grant is made.
  assign w_gnt = w_search_hit;

`ifdef IMEM_ARB_BURST_LOCK_EN
  localparam int CW = 4;

  logic [CW-1:0] r_cnt;
  logic [PW-1:0] r_owner;

  // r_cnt is nonzero only if the previous cycle produced a grant.
  assign w_lock = (r_cnt != '0) && w_req[r_owner] && (r_cnt < CW'(MAX_BURST));
  assign w_g    = w_lock ? r_owner : w_search_idx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt   <= '0;
      r_owner <= '0;
    end else if (!w_gnt) begin
      r_cnt   <= '0;
    end else if (w_lock) begin
      r_cnt   <= r_cnt + 1'b1;
    end else begin
      r_cnt   <= CW'(1);
      r_owner <= w_g;
    end
  end
`else
  assign w_lock = 1'b0;
  assign w_g    = w_search_idx;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr    <= '0;
      r_rvalid <= '0;
    end else begin
      r_rvalid <= (w_gnt && bus.req_wr_x[w_g]) ? (PORTS'(1) << w_g) : '0;
      // During a locked run the pointer stays put so round-robin resumes
      // from owner+1 once the burst ends.
      if (w_gnt && !w_lock) begin
        r_ptr <= (w_g == PW'(PORTS - 1)) ? '0 : (w_g + 1'b1);
      end
    end
  end

  // Idle drives the memory inactive but still routes port 0's address and
  // data so the memory pins never float.
  always_comb begin
    bus.mem_en_x     = 1'b1;
    bus.mem_wr_x     = 1'b1;
    bus.mem_bit_wr_x = '1;
    bus.mem_addr     = bus.req_addr[0 +: ADDRWIDTH];
    bus.mem_d        = bus.req_d[0 +: PORTW];
    bus.busy         = '0;
    bus.grant_id     = 3'd0;
    if (w_gnt) begin
      bus.mem_en_x     = bus.req_en_x[w_g];
      bus.mem_wr_x     = bus.req_wr_x[w_g];
      bus.mem_bit_wr_x = bus.req_bit_wr_x[int'(w_g) * PORTW +: PORTW];
      bus.mem_addr     = bus.req_addr[int'(w_g) * ADDRWIDTH +: ADDRWIDTH];
      bus.mem_d        = bus.req_d[int'(w_g) * PORTW +: PORTW];
      bus.busy         = w_req & ~(PORTS'(1) << w_g);
      bus.grant_id     = 3'(w_g);
    end
  end

  assign bus.q      = bus.mem_q;
  assign bus.rvalid = r_rvalid;

endmodule
